// File: rtl/palette_lookup_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : palette_lookup_arbiter
// Purpose  : Round-robin arbiter that shares one 16-entry sprite palette ROM
//            (index -> 12-bit RGB) between N_REQ pixel engines. The granted
//            lookup runs through a 2-stage pipeline: select/latch, then palette
//            read, transparency detect and global fade scaling.
// Ports    : Clk, Reset_n      clock / asynchronous active-low reset
//            req, req_index    per-requester request and packed palette index
//            gnt               one-hot grant, combinational in the request cycle
//            stall             freezes pipeline and pointer, suppresses grants
//            fade_level        global brightness 0..15, sampled at grant time
//            rsp_valid/rsp_id  response strobe and owning requester
//            rsp_red/green/blue scaled colour channels, rsp_transp flag
// Revision : 1.0  initial release
// ============================================================================
module palette_lookup_arbiter #(
    parameter int N_REQ     = 4,
    parameter int IDX_W     = 4,
    parameter int TRANS_IDX = 2
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*IDX_W-1:0]     req_index,
    output logic [N_REQ-1:0]           gnt,
    input  logic                       stall,
    input  logic [3:0]                 fade_level,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [3:0]                 rsp_red,
    output logic [3:0]                 rsp_green,
    output logic [3:0]                 rsp_blue,
    output logic                       rsp_transp
);

    localparam int ID_W = $clog2(N_REQ);

    // Palette contents. Index 2 is the transparent slot and is kept black.
    function automatic logic [11:0] f_palette(input logic [IDX_W-1:0] idx);
        logic [11:0] rgb;
        case (int'(idx))
            0:       rgb = 12'h000;
            1:       rgb = 12'hFFF;
            2:       rgb = 12'h000;
            3:       rgb = 12'hBBF;
            4:       rgb = 12'hF00;
            5:       rgb = 12'h0F0;
            6:       rgb = 12'h00F;
            7:       rgb = 12'hFF0;
            8:       rgb = 12'h0FF;
            9:       rgb = 12'hF0F;
            10:      rgb = 12'h888;
            11:      rgb = 12'hDDE;
            12:      rgb = 12'h444;
            13:      rgb = 12'hF80;
            14:      rgb = 12'h8F8;
            15:      rgb = 12'h48C;
            default: rgb = 12'h000;
        endcase
        return rgb;
    endfunction

    // 4b channel x 5b multiplier (fade+1); result bits [7:4] are the scaled value.
    function automatic logic [3:0] f_scale(input logic [3:0] c, input logic [4:0] m);
        return 4'(({5'b0, c} * {4'b0, m}) >> 4);
    endfunction

    // Unpacked view of the requester indices.
    logic [IDX_W-1:0] w_idx_arr [N_REQ];

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_idx_arr[g] = req_index[g*IDX_W +: IDX_W];
        end
    endgenerate

    // Registered state
    logic [ID_W-1:0]  r_rr_ptr;
    logic             r_s1_valid;
    logic [ID_W-1:0]  r_s1_id;
    logic [IDX_W-1:0] r_s1_idx;
    logic [3:0]       r_s1_fade;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [3:0]       r_rsp_red;
    logic [3:0]       r_rsp_green;
    logic [3:0]       r_rsp_blue;
    logic             r_rsp_transp;

    // Combinational arbitration
    logic [N_REQ-1:0] w_gnt;
    logic [ID_W-1:0]  w_sel;
    logic             w_found;
    logic             w_xfer;
    int               w_j;

    // Scan upward from the slot after the last winner, wrapping at N_REQ-1.
    // Grants are suppressed during stall and while reset is asserted.
    always_comb begin : p_arb
        w_gnt   = '0;
        w_sel   = '0;
        w_found = 1'b0;
        w_j     = 0;
        if (Reset_n && !stall) begin
            for (int k = 1; k <= N_REQ; k++) begin
                w_j = (int'(r_rr_ptr) + k) % N_REQ;
                if (!w_found && req[ID_W'(w_j)]) begin
                    w_found             = 1'b1;
                    w_gnt[ID_W'(w_j)]   = 1'b1;
                    w_sel               = ID_W'(w_j);
                end
            end
        end
    end

    assign w_xfer = |(req & w_gnt);

    // Stage 2 datapath from the latched stage-1 lookup
    logic [11:0] w_rgb;
    logic [4:0]  w_mult;

    assign w_rgb  = f_palette(r_s1_idx);
    assign w_mult = {1'b0, r_s1_fade} + 5'd1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rr_ptr     <= ID_W'(N_REQ - 1);
            r_s1_valid   <= 1'b0;
            r_s1_id      <= '0;
            r_s1_idx     <= '0;
            r_s1_fade    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_red    <= '0;
            r_rsp_green  <= '0;
            r_rsp_blue   <= '0;
            r_rsp_transp <= 1'b0;
        end else if (!stall) begin
            // Stage 1: latch the winner; fade is captured per lookup here.
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_rr_ptr  <= w_sel;
                r_s1_id   <= w_sel;
                r_s1_idx  <= w_idx_arr[w_sel];
                r_s1_fade <= fade_level;
            end
            // Stage 2: palette read, fade scaling, transparency detect.
            r_rsp_valid  <= r_s1_valid;
            r_rsp_id     <= r_s1_id;
            r_rsp_red    <= f_scale(w_rgb[11:8], w_mult);
            r_rsp_green  <= f_scale(w_rgb[7:4],  w_mult);
            r_rsp_blue   <= f_scale(w_rgb[3:0],  w_mult);
            r_rsp_transp <= (r_s1_idx == IDX_W'(TRANS_IDX));
        end
    end

    assign gnt        = w_gnt;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_red    = r_rsp_red;
    assign rsp_green  = r_rsp_green;
    assign rsp_blue   = r_rsp_blue;
    assign rsp_transp = r_rsp_transp;

endmodule
`default_nettype wire
